branch_predictor: RTL and testbench

//   Bimodal direction predictor, fetch side. One-cycle registered lookup from fetch PC gives predicted_taken_out.

---
 rtl/branch_predictor.sv | 83 ++++++++
 tb/tb_branch_predictor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: registered lookup from fetch PC, 2-bit saturating counters trained at resolve.
// Optional gshare hashing with a global history register when BRANCH_PREDICTOR_GSHARE_EN is defined.
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic                  lookup_valid_in,
    input  logic [63:0]           lookup_pc_in,
    output logic                  predicted_valid_out,
    output logic                  predicted_taken_out,
    output logic [INDEX_BITS-1:0] predicted_index_out,
    input  logic                  update_valid_in,
    input  logic [INDEX_BITS-1:0] update_index_in,
    input  logic                  update_taken_in
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            ctr [ENTRIES];
    logic [INDEX_BITS-1:0] idx;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_next;
    logic                  unused_pc;

    assign unused_pc = ^{lookup_pc_in[63:INDEX_BITS+2], lookup_pc_in[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    // History advances only on resolved branches, so it never needs repair.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (update_valid_in) begin
            ghr <= {ghr[INDEX_BITS-2:0], update_taken_in};
        end
    end

    assign idx = lookup_pc_in[INDEX_BITS+1:2] ^ ghr;
`else
    assign idx = lookup_pc_in[INDEX_BITS+1:2];
`endif

    always_comb begin
        upd_cur  = ctr[update_index_in];
        upd_next = upd_cur;
        if (update_taken_in) begin
            if (upd_cur != 2'b11) begin
                upd_next = upd_cur + 2'd1;
            end
        end else begin
            if (upd_cur != 2'b00) begin
                upd_next = upd_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (update_valid_in) begin
            ctr[update_index_in] <= upd_next;
        end
    end

    // Lookup reads the table before this edge's update lands: no bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            predicted_valid_out <= 1'b0;
            predicted_taken_out <= 1'b0;
            predicted_index_out <= '0;
        end else if (!stall_in) begin
            predicted_valid_out <= lookup_valid_in;
            predicted_taken_out <= lookup_valid_in & ctr[idx][1];
            predicted_index_out <= idx;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (INDEX_BITS=6).
// Each record is one clock: drive inputs, clock edge, then compare {valid, taken, index}.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        lookup_valid_in;
    logic [63:0] lookup_pc_in;
    logic        predicted_valid_out;
    logic        predicted_taken_out;
    logic [5:0]  predicted_index_out;
    logic        update_valid_in;
    logic [5:0]  update_index_in;
    logic        update_taken_in;

    int compared;
    int mismatched;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_in            (stall_in),
        .lookup_valid_in     (lookup_valid_in),
        .lookup_pc_in        (lookup_pc_in),
        .predicted_valid_out (predicted_valid_out),
        .predicted_taken_out (predicted_taken_out),
        .predicted_index_out (predicted_index_out),
        .update_valid_in     (update_valid_in),
        .update_index_in     (update_index_in),
        .update_taken_in     (update_taken_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        lv;
        logic [63:0] pc;
        logic        uv;
        logic [5:0]  uidx;
        logic        ut;
        logic        chk;
        logic        ev;
        logic        et;
        logic [5:0]  ei;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name, input logic rst, input logic stall,
                                input logic lv, input logic [63:0] pc, input logic uv,
                                input logic [5:0] uidx, input logic ut, input logic chk,
                                input logic ev, input logic et, input logic [5:0] ei);
        vec_t v;
        v.name = name; v.rst = rst; v.stall = stall; v.lv = lv; v.pc = pc;
        v.uv = uv; v.uidx = uidx; v.ut = ut; v.chk = chk;
        v.ev = ev; v.et = et; v.ei = ei;
        return v;
    endfunction

    task automatic step(input logic rst, input logic stall, input logic lv, input logic [63:0] pc,
                        input logic uv, input logic [5:0] uidx, input logic ut);
        @(negedge clk);
        reset           = rst;
        stall_in        = stall;
        lookup_valid_in = lv;
        lookup_pc_in    = pc;
        update_valid_in = uv;
        update_index_in = uidx;
        update_taken_in = ut;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic et, input logic [5:0] ei);
        compared++;
        if ({predicted_valid_out, predicted_taken_out, predicted_index_out} !== {ev, et, ei}) begin
            mismatched++;
            $display("FAIL %s: got valid=%0b taken=%0b index=0x%02h, want valid=%0b taken=%0b index=0x%02h",
                     name, predicted_valid_out, predicted_taken_out, predicted_index_out, ev, et, ei);
        end
    endtask

    task automatic upd(input logic [5:0] i, input logic t, input int n);
        for (int k = 0; k < n; k++) tbl.push_back(mk("upd", 0, 0, 0, 64'h0, 1, i, t, 0, 0, 0, 6'h0));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset = 1'b1; stall_in = 1'b0; lookup_valid_in = 1'b0; lookup_pc_in = '0;
        update_valid_in = 1'b0; update_index_in = '0; update_taken_in = 1'b0;

`ifndef BRANCH_PREDICTOR_GSHARE_EN
        // reset state and basic lookup
        tbl.push_back(mk("reset",      1, 0, 0, 64'h0,   0, 6'd0, 0, 1, 0, 0, 6'd0));
        tbl.push_back(mk("lk104_init", 0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 0, 6'd1));
        tbl.push_back(mk("lk_invalid", 0, 0, 0, 64'h104, 0, 6'd0, 0, 1, 0, 0, 6'd1));
        // training walk 01 -> 10 -> 11 -> 10 -> 01
        tbl.push_back(mk("upd_idle",   0, 0, 0, 64'h0,   1, 6'd1, 1, 1, 0, 0, 6'd0));
        upd(6'd1, 1, 1);
        tbl.push_back(mk("lk_ctr11",   0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 1, 6'd1));
        upd(6'd1, 0, 1);
        tbl.push_back(mk("lk_ctr10",   0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 1, 6'd1));
        upd(6'd1, 0, 1);
        tbl.push_back(mk("lk_ctr01",   0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 0, 6'd1));
        // saturation at both ends
        upd(6'd1, 1, 5); upd(6'd1, 0, 1);
        tbl.push_back(mk("sat_hi",     0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 1, 6'd1));
        upd(6'd1, 0, 5); upd(6'd1, 1, 1);
        tbl.push_back(mk("sat_lo",     0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 0, 6'd1));
        // aliasing and same-cycle collision (pre-update value returned)
        upd(6'd1, 1, 2);
        tbl.push_back(mk("alias204",   0, 0, 1, 64'h204, 0, 6'd0, 0, 1, 1, 1, 6'd1));
        upd(6'd1, 0, 2);
        tbl.push_back(mk("collide",    0, 0, 1, 64'h104, 1, 6'd1, 1, 1, 1, 0, 6'd1));
        tbl.push_back(mk("post_coll",  0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 1, 6'd1));
        // top index, independent from neighbour
        tbl.push_back(mk("idx63_init", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 6'd0, 0, 1, 1, 0, 6'd63));
        upd(6'd63, 1, 2);
        tbl.push_back(mk("idx63_tr",   0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 6'd0, 0, 1, 1, 1, 6'd63));
        tbl.push_back(mk("idx62",      0, 0, 1, 64'hF8,  0, 6'd0, 0, 1, 1, 0, 6'd62));
        // stall holds outputs; update still commits during stall
        tbl.push_back(mk("pre_stall",  0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 1, 6'd1));
        tbl.push_back(mk("stall_upd",  0, 1, 1, 64'h108, 1, 6'd2, 1, 1, 1, 1, 6'd1));
        tbl.push_back(mk("stall_nolk", 0, 1, 0, 64'h108, 0, 6'd0, 0, 1, 1, 1, 6'd1));
        tbl.push_back(mk("unstall108", 0, 0, 1, 64'h108, 0, 6'd0, 0, 1, 1, 1, 6'd2));
        // reset during training wins
        tbl.push_back(mk("rst_midupd", 1, 0, 1, 64'h104, 1, 6'd1, 1, 1, 0, 0, 6'd0));
        tbl.push_back(mk("rst_ctr1",   0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 0, 6'd1));
        tbl.push_back(mk("rst_ctr2",   0, 0, 1, 64'h108, 0, 6'd0, 0, 1, 1, 0, 6'd2));
        tbl.push_back(mk("rst_ctr63",  0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 6'd0, 0, 1, 1, 0, 6'd63));
        upd(6'd1, 1, 1);
        tbl.push_back(mk("rst_is_01",  0, 0, 1, 64'h104, 0, 6'd0, 0, 1, 1, 1, 6'd1));

        foreach (tbl[n]) begin
            step(tbl[n].rst, tbl[n].stall, tbl[n].lv, tbl[n].pc, tbl[n].uv, tbl[n].uidx, tbl[n].ut);
            if (tbl[n].chk) check(tbl[n].name, tbl[n].ev, tbl[n].et, tbl[n].ei);
        end

        // Hand sequence: multi-cycle stall with changing requests, then reset under stall.
        step(0, 0, 1, 64'h104, 0, 6'd0, 0);
        check("hs_lookup", 1, 1, 6'd1);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, k[0], 64'h108 + 64'(k * 4), 0, 6'd0, 0);
            check("hs_stall_hold", 1, 1, 6'd1);
        end
        step(1, 1, 1, 64'h108, 0, 6'd0, 0);
        check("hs_reset_stall", 0, 0, 6'd0);
`else
        // Hand sequence for the gshare build: index hashed with resolved-branch history.
        step(1, 0, 0, 64'h0,   0, 6'd0, 0);
        check("gs_reset", 0, 0, 6'd0);
        step(0, 0, 0, 64'h0,   1, 6'd0, 1);
        step(0, 0, 0, 64'h0,   1, 6'd0, 1);
        step(0, 0, 1, 64'h104, 0, 6'd0, 0);
        check("gs_hash104", 1, 0, 6'd2);
        step(0, 0, 1, 64'h0C,  0, 6'd0, 0);
        check("gs_hash0c", 1, 1, 6'd0);
        step(1, 0, 0, 64'h0,   0, 6'd0, 0);
        check("gs_reset2", 0, 0, 6'd0);
        step(0, 0, 1, 64'h104, 0, 6'd0, 0);
        check("gs_ghr_clr", 1, 0, 6'd1);
        step(0, 0, 0, 64'h0,   1, 6'd5, 0);
        step(0, 0, 1, 64'h104, 0, 6'd0, 0);
        check("gs_hist_nt", 1, 0, 6'd1);
        step(0, 0, 0, 64'h0,   1, 6'd5, 1);
        step(0, 0, 1, 64'h104, 0, 6'd0, 0);
        check("gs_hist_t", 1, 0, 6'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
